// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM state encoding
// and flag bit positions within the 5-bit flags word.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // flags = {err, neg, zero, ovf, car}
    localparam int FLAG_CAR  = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 3;
    localparam int FLAG_ERR  = 4;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath. MUL is handled by the iterative
// multiplier in seq_alu; here it only reports err when multiply is disabled.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] res,
    output logic [4:0]       flags
);

    localparam int SH = $clog2(WIDTH);

    logic [SH-1:0]    shamt;
    logic [WIDTH-1:0] r;
    logic             car;
    logic             ovf;
    logic             err;

    assign shamt = b[SH-1:0];

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        r   = '0;
        car = 1'b0;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADD: begin
                {car, r} = {1'b0, a} + {1'b0, b};
                ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {car, r} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r[0] = ($signed(a) < $signed(b));
            OP_EQ:   r[0] = (a == b);
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a >> shamt;
            OP_SRA:  r = $signed(a) >>> shamt;
            OP_MUL:  err = (MUL_EN == 0);
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        flags = '0;
        res   = '0;
        if (err) begin
            flags[FLAG_ERR] = 1'b1;
        end else begin
            res              = r;
            flags[FLAG_NEG]  = r[WIDTH-1];
            flags[FLAG_ZERO] = (r == '0);
            flags[FLAG_OVF]  = ovf;
            flags[FLAG_CAR]  = car;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, result hold registers and a
// WIDTH-cycle unsigned shift-add multiplier around the alu_core datapath.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [4:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

    logic [1:0]         state;
    logic [WIDTH-1:0]   core_res;
    logic [4:0]         core_flags;
    logic               accept;
    logic               is_mul;

    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_mcand;
    logic [CW-1:0]      mul_cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_res;
    logic [4:0]         mul_flags;

    alu_core #(
        .WIDTH  (WIDTH),
        .MUL_EN (MUL_EN)
    ) u_core (
        .a     (a),
        .b     (b),
        .op    (op),
        .res   (core_res),
        .flags (core_flags)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign is_mul = (op == OP_MUL) && (MUL_EN != 0);

    // Product register starts as {0, multiplier}; each step adds the
    // multiplicand into the upper half when the low bit is set, then shifts right.
    assign mul_sum = {1'b0, mul_prod[2*WIDTH-1:WIDTH]} + (mul_prod[0] ? {1'b0, mul_mcand} : '0);
    assign mul_res = mul_prod[WIDTH-1:0];

    always_comb begin
        mul_flags            = '0;
        mul_flags[FLAG_NEG]  = mul_res[WIDTH-1];
        mul_flags[FLAG_ZERO] = (mul_res == '0);
        mul_flags[FLAG_OVF]  = |mul_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            flags     <= '0;
            // NOTE: multiplier datapath registers are reset too, so a multiply abandoned by reset leaves nothing stale.
            mul_prod  <= '0;
            mul_mcand <= '0;
            mul_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                            mul_prod  <= {{WIDTH{1'b0}}, b};
                            mul_mcand <= a;
                            mul_cnt   <= '0;
                        end else begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            res       <= core_res;
                            flags     <= core_flags;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == CNT_DONE) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        res       <= mul_res;
                        flags     <= mul_flags;
                    end else begin
                        mul_prod <= {mul_sum, mul_prod[WIDTH-1:1]};
                        mul_cnt  <= mul_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [4:0]   flags;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic [4:0] flags;
    } exp_t;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH  (W),
        .MUL_EN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb, input logic [3:0] o);
        int   ua  = int'(xa);
        int   ub  = int'(xb);
        int   sa  = (ua > 127) ? ua - 256 : ua;
        int   sb  = (ub > 127) ? ub - 256 : ub;
        int   sh  = ub % 8;
        int   r   = 0;
        bit   car = 1'b0;
        bit   ovf = 1'b0;
        exp_t e;
        case (o)
            4'd0: begin r = ua + ub; car = (r > 255); ovf = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ua + (255 - ub) + 1; car = (r > 255); ovf = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = 255 - ua;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = (sa < sb) ? 1 : 0;
            4'd7: r = (ua == ub) ? 1 : 0;
            4'd8: r = ua << sh;
            4'd9: r = ua >> sh;
            4'd10: r = sa >>> sh;
            4'd11: begin r = ua * ub; ovf = (r > 255); end
            default: begin
                e.res   = 8'd0;
                e.flags = 5'b10000;
                return e;
            end
        endcase
        e.res   = 8'(r & 255);
        e.flags = {1'b0, e.res[7], e.res == 8'd0, ovf, car};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1 and check handshake, latency and result.
    task automatic run_op(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib, input string tag);
        exp_t e;
        int   n;
        bit   busy_ok;
        e = model(ia, ib, o);
        @(negedge clk);
        a = ia; b = ib; op = o; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (o == 4'd11) begin
            n       = 0;
            busy_ok = 1'b1;
            while (!out_valid && n < 40) begin
                if (in_ready) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
            check({tag, " mul_latency"}, 32'(n), 32'd9);
            check({tag, " mul_busy"}, 32'(busy_ok), 32'd1);
        end else begin
            check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        end
        check({tag, " res"}, 32'(res), 32'(e.res));
        check({tag, " flags"}, 32'(flags), 32'(e.flags));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        #23;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset res", 32'(res), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op(4'd0, 8'h7F, 8'h01, "add_ovf");
        check("add_ovf literal res", 32'(res), 32'h80);
        check("add_ovf literal flags", 32'(flags), 32'b01010);
        run_op(4'd1, 8'h05, 8'h05, "sub_zero");
        check("sub_zero literal flags", 32'(flags), 32'b00101);
        run_op(4'd6, 8'hFF, 8'h01, "slt_neg");
        check("slt_neg literal res", 32'(res), 32'd1);
        run_op(4'd11, 8'h10, 8'h11, "mul");
        check("mul literal res", 32'(res), 32'h10);
        check("mul literal ovf", 32'(flags[1]), 32'd1);
        run_op(4'd13, 8'hA5, 8'h3C, "illegal");
        check("illegal literal flags", 32'(flags), 32'b10000);
        run_op(4'd10, 8'h80, 8'h0B, "sra");
        check("sra literal res", 32'(res), 32'hF0);

        // Result is consumed; registers keep their last value while idle.
        @(posedge clk);
        #1;
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle res retained", 32'(res), 32'hF0);

        // Stall the consumer, then consume and issue in the same cycle.
        e = model(8'h3A, 8'h4C, 4'd0);
        @(negedge clk);
        a = 8'h3A; b = 8'h4C; op = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall res", 32'(res), 32'(e.res));
            check("stall flags", 32'(flags), 32'(e.flags));
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 8'hF0; b = 8'hFF; op = 4'd5;
        #1;
        check("passthrough in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b out_valid", 32'(out_valid), 32'd1);
        check("b2b res", 32'(res), 32'h0F);

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 8'h33; b = 8'h47; op = 4'd11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul reset out_valid", 32'(out_valid), 32'd0);
        check("midmul reset res", 32'(res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midmul no result", 32'(seen), 32'd0);
        check("midmul in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 120; i++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
